serial_sub_ctrl: RTL and testbench
==================================

// Module: serial_sub_ctrl
// PURPOSE
//  Sequencer that time-shares one full-subtractor cell (two half-subtractor stages) across
//  WIDTH bits, LSB first, to form A-B with borrow. Area-lean subtract path for the complex
//  multiplier real-part (ac-bd) term. Start/done handshake toward the multiplier control.
// PARAMETERS
//  WIDTH   16   operand/result width in bits; legal range 1..64
// PORTS
//  clk     in   1       single clock; all state updates on rising edge
//  rst     in   1       asynchronous, active-high reset
//  start   in   1       request; sampled only when ready (state IDLE or DONE)
//  a       in   WIDTH   minuend; captured on the edge that accepts start
//  b       in   WIDTH   subtrahend; captured on the edge that accepts start
//  busy    out  1       1 while in RUN
//  done    out  1       one-cycle pulse: d/bout valid
//  d       out  WIDTH   difference; held until the next accepted start completes
//  bout    out  1       final borrow (1 => a<b unsigned); held like d
// BEHAVIOUR
//  - Reset (async, any state, including mid-RUN): state=IDLE, busy=0, done=0, d=0, bout=0,
//    bit counter=0, borrow=0, shift regs=0. The in-flight operation is discarded.
//  - FSM states: IDLE, RUN, DONE. Encoding is in the package.
//    IDLE --start--> RUN: load a,b into shift regs, borrow=0, cnt=0.
//    RUN: each cycle, cell input is (sa[0], sb[0], borrow).
//         diff = sa0^sb0^bin; bnext = (~sa0&sb0) | (~(sa0^sb0)&bin).
//         diff shifts into the MSB of the result reg; sa, sb shift right; cnt++.
//         When cnt==WIDTH-1, go to DONE on the same edge.
//    DONE: done=1 for exactly this cycle; d/bout drive final values. Next edge: start=1 ->
//         RUN (back-to-back accept, same load as IDLE); otherwise -> IDLE.
//  - start in RUN is ignored (no queueing). No abort input exists.
//  - Latency: start accepted on edge k -> done high in the cycle after edge k+WIDTH.
//    Throughput: one result per WIDTH+1 cycles.
//  - Counter width: $clog2(WIDTH+1). WIDTH=1 gives one RUN cycle.
//  - d and bout update only on entry to DONE. They do not change during RUN, and they
//    keep their last values in IDLE.
//  - Arithmetic is unsigned modulo 2^WIDTH. bout is the borrow out of the MSB.
// CONFIGURATION
//  Macro SERIAL_SUB_SAT_EN:
//   defined   -> on entry to DONE, if the final borrow is 1, d is forced to 0
//                (clamp at zero); bout still reports 1.
//   undefined -> d is the wrap-around difference; bout reports the borrow.
//   Latency and handshake are identical in both builds.
// STRUCTURE
//  - Package serial_sub_pkg: FSM state localparams/enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//  - Sub-module fs_cell(a,b,bin,d,bout): combinational full subtractor built from two
//    half-subtractor instances plus an OR for the borrow. It is the only arithmetic
//    instance in the block.
//  - Top: FSM, bit counter, two operand shift regs, result shift reg, borrow flop.
// TESTING (WIDTH=8 unless noted)
//  1. a=8'd5, b=8'd3, start 1 cycle -> done 9 clocks later, d=8'h02, bout=0, busy high 8 cycles.
//  2. a=8'd3, b=8'd5 -> d=8'hFE, bout=1. With SERIAL_SUB_SAT_EN: d=8'h00, bout=1.
//  3. Edge cases: a=b=8'hFF -> d=0, bout=0; a=0, b=8'hFF -> d=8'h01, bout=1;
//     a=0, b=0 -> d=0, bout=0.
//  4. start held high plus new a/b during RUN -> ignored; result matches the first
//     operands. start held into DONE -> second op accepted back-to-back, done pulses
//     every 9 cycles.
//  5. rst asserted at RUN cycle 4 -> busy, done, d, bout = 0 immediately (async).
//     Next start gives a correct result.
//  6. WIDTH=1: all 4 input combos -> done 2 clocks after start. (1,0)->d=1,bout=0;
//     (0,1)->d=1,bout=1 (sat: d=0).

Source files
------------

// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor sequencer.
//   state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : serial_sub_pkg

// File: rtl/fs_cell.sv
// -----------------------------------------------------------------------------
// half_sub / fs_cell
// Combinational subtractor cells.
//   half_sub : i_x - i_y -> o_d (difference), o_b (borrow)
//   fs_cell  : a - b - bin -> d (difference), bout (borrow out)
//              built from two half_sub stages plus an OR on the borrows.
// -----------------------------------------------------------------------------
module half_sub (
   input  logic i_x,
   input  logic i_y,
   output logic o_d,
   output logic o_b
);
   assign o_d = i_x ^ i_y;
   assign o_b = ~i_x & i_y;
endmodule : half_sub

module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic w_d1;
   logic w_b1;
   logic w_b2;

   half_sub u_hs0 (.i_x(a),    .i_y(b),   .o_d(w_d1), .o_b(w_b1));
   // Second stage subtracts the incoming borrow from the first-stage difference.
   half_sub u_hs1 (.i_x(w_d1), .i_y(bin), .o_d(d),    .o_b(w_b2));

   assign bout = w_b1 | w_b2;
endmodule : fs_cell

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial A-B sequencer: one fs_cell is reused WIDTH times, LSB first.
// Start/done handshake; result held until the next accepted start completes.
//
// Parameters
//   WIDTH : operand/result width, 1..64
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request, accepted in IDLE or DONE
//   a, b  : minuend / subtrahend, captured when start is accepted
//   busy  : 1 while the bit loop runs
//   done  : one-cycle pulse, d/bout valid
//   d     : difference (held)
//   bout  : borrow out of the MSB, 1 => a < b unsigned (held)
// Build option
//   SERIAL_SUB_SAT_EN : when defined, d clamps to zero if the final borrow is 1.
// -----------------------------------------------------------------------------
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_last;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic             r_borrow;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_d;
   logic             r_bout;

   logic             w_diff;
   logic             w_bnext;
   logic [WIDTH-1:0] w_diff_msb;
   logic [WIDTH-1:0] w_res_nxt;
   logic [WIDTH-1:0] w_d_final;

   // The single arithmetic cell, fed from the shift-register LSBs.
   fs_cell u_cell (
      .a    (r_sa[0]),
      .b    (r_sb[0]),
      .bin  (r_borrow),
      .d    (w_diff),
      .bout (w_bnext)
   );

   // Next-state decode and load strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = (r_cnt == CNT_LAST);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_DONE: begin
            // Back-to-back accept: a new start loads operands exactly as from IDLE.
            if (start) begin
               w_state_nxt = ST_RUN;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Result shift: the new difference bit enters at the MSB so that after WIDTH
   // shifts the LSB-first bits land in their natural positions.
   always_comb begin
      w_diff_msb            = {WIDTH{1'b0}};
      w_diff_msb[WIDTH-1]   = w_diff;
      w_res_nxt             = (r_res >> 1) | w_diff_msb;
`ifdef SERIAL_SUB_SAT_EN
      if (w_bnext) begin
         w_d_final = {WIDTH{1'b0}};
      end else begin
         w_d_final = w_res_nxt;
      end
`else
      w_d_final = w_res_nxt;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath: operand/result shift registers, borrow flop and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa     <= {WIDTH{1'b0}};
         r_sb     <= {WIDTH{1'b0}};
         r_res    <= {WIDTH{1'b0}};
         r_borrow <= 1'b0;
         r_cnt    <= {CW{1'b0}};
      end else if (w_load) begin
         r_sa     <= a;
         r_sb     <= b;
         r_res    <= {WIDTH{1'b0}};
         r_borrow <= 1'b0;
         r_cnt    <= {CW{1'b0}};
      end else if (r_state == ST_RUN) begin
         r_sa     <= r_sa >> 1;
         r_sb     <= r_sb >> 1;
         r_res    <= w_res_nxt;
         r_borrow <= w_bnext;
         r_cnt    <= r_cnt + CNT_ONE;
      end
   end

   // Registered outputs; d/bout change only on the edge entering DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_d    <= {WIDTH{1'b0}};
         r_bout <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt == ST_RUN);
         r_done <= (w_state_nxt == ST_DONE);
         if ((r_state == ST_RUN) && w_last) begin
            r_d    <= w_d_final;
            r_bout <= w_bnext;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign d    = r_d;
   assign bout = r_bout;

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
// Self-checking bench: an 8-bit and a 1-bit instance of serial_sub_ctrl are
// driven with directed and random operations and compared against an
// arithmetic reference (a-b modulo 2^W, borrow = a<b, optional clamp).
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

   logic       clk;
   logic       rst8;
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       busy8;
   logic       done8;
   logic [7:0] d8;
   logic       bout8;

   logic       rst1;
   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       busy1;
   logic       done1;
   logic [0:0] d1;
   logic       bout1;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected held outputs of the 8-bit instance (last completed operation).
   logic [7:0] exp_d8_hold;
   logic       exp_b8_hold;

   serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .d(d8), .bout(bout8)
   );

   serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .d(d1), .bout(bout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned subtraction modulo 2^w, borrow when a<b.
   task automatic model(input int w, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] ed, output logic eb);
      logic [63:0] mask;
      mask = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
      eb   = ((x & mask) < (y & mask));
      ed   = (x - y) & mask;
`ifdef SERIAL_SUB_SAT_EN
      if (eb) ed = 64'd0;
`endif
   endtask

   // Accept one operation on the 8-bit instance and check latency, busy, hold and result.
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input string tag);
      logic [63:0] ed;
      logic        eb;
      int          lat;
      int          bcnt;
      model(8, {56'd0, x}, {56'd0, y}, ed, eb);
      a8 = x; b8 = y; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0; bcnt = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         if (busy8 === 1'b1) bcnt++;
         if (lat == 4) begin
            check($sformatf("%s_hold_d", tag), {56'd0, d8}, {56'd0, exp_d8_hold});
            check($sformatf("%s_hold_b", tag), {63'd0, bout8}, {63'd0, exp_b8_hold});
         end
         tick();
         lat++;
      end
      check($sformatf("%s_lat", tag), 64'(lat), 64'd8);
      check($sformatf("%s_busycnt", tag), 64'(bcnt), 64'd8);
      check($sformatf("%s_d", tag), {56'd0, d8}, ed);
      check($sformatf("%s_bout", tag), {63'd0, bout8}, {63'd0, eb});
      exp_d8_hold = ed[7:0];
      exp_b8_hold = eb;
      tick();
      check($sformatf("%s_pulse", tag), {63'd0, done8}, 64'd0);
   endtask

   task automatic op1(input logic x, input logic y, input string tag);
      logic [63:0] ed;
      logic        eb;
      int          lat;
      model(1, {63'd0, x}, {63'd0, y}, ed, eb);
      a1 = x; b1 = y; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      lat = 0;
      while (done1 !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      check($sformatf("%s_lat", tag), 64'(lat), 64'd1);
      check($sformatf("%s_d", tag), {63'd0, d1}, ed);
      check($sformatf("%s_bout", tag), {63'd0, bout1}, {63'd0, eb});
      tick();
      check($sformatf("%s_pulse", tag), {63'd0, done1}, 64'd0);
   endtask

   initial begin
      logic [63:0] ed;
      logic        eb;
      logic [7:0]  x;
      logic [7:0]  y;
      int          lat;

      rst8 = 1'b1; rst1 = 1'b1;
      start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
      exp_d8_hold = 8'd0; exp_b8_hold = 1'b0;
      tick(); tick();
      check("rst_busy", {63'd0, busy8}, 64'd0);
      check("rst_done", {63'd0, done8}, 64'd0);
      check("rst_d",    {56'd0, d8},    64'd0);
      check("rst_bout", {63'd0, bout8}, 64'd0);
      @(negedge clk);
      rst8 = 1'b0; rst1 = 1'b0;
      tick();

      // Directed cases, including edge operands.
      op8(8'd5,   8'd3,   "t1_5m3");
      op8(8'd3,   8'd5,   "t2_3m5");
      op8(8'hFF,  8'hFF,  "t3_ffmff");
      op8(8'h00,  8'hFF,  "t3_0mff");
      op8(8'h00,  8'h00,  "t3_0m0");

      // Random operations.
      for (int i = 0; i < 20; i++) begin
         op8(8'($urandom), 8'($urandom), $sformatf("rnd%0d", i));
      end

      // start held through RUN with changing operands: ignored, then back-to-back accept.
      x = 8'($urandom); y = 8'($urandom);
      model(8, {56'd0, x}, {56'd0, y}, ed, eb);
      a8 = x; b8 = y; start8 = 1'b1;
      tick();
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         tick();
         lat++;
      end
      check("t4_first_lat", 64'(lat), 64'd8);
      check("t4_first_d",   {56'd0, d8},    ed);
      check("t4_first_b",   {63'd0, bout8}, {63'd0, eb});
      x = 8'($urandom); y = 8'($urandom);
      model(8, {56'd0, x}, {56'd0, y}, ed, eb);
      a8 = x; b8 = y;
      tick();
      start8 = 1'b0;
      check("t4_b2b_busy", {63'd0, busy8}, 64'd1);
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      check("t4_b2b_interval", 64'(lat + 1), 64'd9);
      check("t4_second_d", {56'd0, d8},    ed);
      check("t4_second_b", {63'd0, bout8}, {63'd0, eb});
      exp_d8_hold = ed[7:0];
      exp_b8_hold = eb;
      tick();

      // Async reset in the middle of RUN, then recovery.
      op8(8'd1, 8'd100, "t5_pre");
      a8 = 8'd77; b8 = 8'd12; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      check("t5_busy_before", {63'd0, busy8}, 64'd1);
      #2;
      rst8 = 1'b1;
      #1;
      check("t5_rst_busy", {63'd0, busy8}, 64'd0);
      check("t5_rst_done", {63'd0, done8}, 64'd0);
      check("t5_rst_d",    {56'd0, d8},    64'd0);
      check("t5_rst_bout", {63'd0, bout8}, 64'd0);
      @(negedge clk);
      rst8 = 1'b0;
      exp_d8_hold = 8'd0;
      exp_b8_hold = 1'b0;
      tick();
      op8(8'd200, 8'd55, "t5_after");

      // WIDTH=1 instance: all input combinations.
      op1(1'b0, 1'b0, "w1_00");
      op1(1'b0, 1'b1, "w1_01");
      op1(1'b1, 1'b0, "w1_10");
      op1(1'b1, 1'b1, "w1_11");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_serial_sub_ctrl
